// File: rtl/mode_record_arbiter.sv
// N-channel {mode,data} record FIFOs merged onto one registered valid/ready
// output; urgent-mode heads win by lowest index, the rest are served round-robin.
module mode_record_arbiter #(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       MODE_W      = 3,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DEPTH       = 4,
  parameter logic [MODE_W-1:0] URGENT_MODE = '0,
  localparam int unsigned      CH_W        = $clog2(NUM_CH),
  localparam int unsigned      LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*MODE_W-1:0]  in_mode,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MODE_W-1:0]         out_mode,
  output logic [DATA_W-1:0]         out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic [NUM_CH*LVL_W-1:0]   ch_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_mem_q [NUM_CH][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wptr_q [NUM_CH];
  logic [PTR_W-1:0]  wptr_d [NUM_CH];
  logic [PTR_W-1:0]  rptr_q [NUM_CH];
  logic [PTR_W-1:0]  rptr_d [NUM_CH];
  logic [LVL_W-1:0]  level_q [NUM_CH];
  logic [LVL_W-1:0]  level_d [NUM_CH];
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [MODE_W-1:0] out_mode_q, out_mode_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic [NUM_CH-1:0] push, pop, nonempty, urgent;
  logic              any_ne, urg_any, load;
  logic [CH_W-1:0]   grant;

  always_comb begin
    in_ready = '0;
    push     = '0;
    nonempty = '0;
    urgent   = '0;
    ch_level = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (level_q[i] != '0);
      in_ready[i] = !rst && (level_q[i] != LVL_W'(DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
      urgent[i]   = nonempty[i] && (mode_mem_q[i][rptr_q[i]] == URGENT_MODE);
      ch_level[i*LVL_W +: LVL_W] = level_q[i];
    end
  end

  // Round-robin search wraps at NUM_CH so non-power-of-2 channel counts work.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant   = '0;
    found   = 1'b0;
    idx     = 0;
    any_ne  = |nonempty;
    urg_any = |urgent;
    if (urg_any) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!found && urgent[i]) begin
          grant = CH_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && nonempty[CH_W'(idx)]) begin
          grant = CH_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    out_mode_d = out_mode_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    load       = 1'b0;
    case (state_q)
      S_EMPTY: load = any_ne;
      S_HOLD: begin
        if (out_ready) begin
          load = any_ne;
          if (!any_ne) state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (load) begin
      state_d    = S_HOLD;
      out_mode_d = mode_mem_q[grant][rptr_q[grant]];
      out_data_d = data_mem_q[grant][rptr_q[grant]];
      out_ch_d   = grant;
      if (!urg_any) rr_d = grant;
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pop[i]    = load && (grant == CH_W'(i));
      wptr_d[i] = wptr_q[i] + PTR_W'(push[i]);
      rptr_d[i] = rptr_q[i] + PTR_W'(pop[i]);
      case ({push[i], pop[i]})
        2'b10:   level_d[i] = level_q[i] + LVL_W'(1);
        2'b01:   level_d[i] = level_q[i] - LVL_W'(1);
        default: level_d[i] = level_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      rr_q       <= CH_W'(NUM_CH - 1);
      out_mode_q <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        level_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      out_mode_q <= out_mode_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        level_q[i] <= level_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers/levels.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mode_mem_q[i][wptr_q[i]] <= in_mode[i*MODE_W +: MODE_W];
        data_mem_q[i][wptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign out_mode  = out_mode_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mode_record_arbiter.sv
// Self-checking bench for mode_record_arbiter: vector table plus scoreboarded
// multi-cycle sequences (fairness, urgent priority, backpressure, wrap, reset).
module tb_mode_record_arbiter;

  localparam int NUM_CH = 4;
  localparam int MODE_W = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;
  localparam int LVL_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*MODE_W-1:0] in_mode = '0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [MODE_W-1:0]        out_mode;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic [NUM_CH*LVL_W-1:0]  ch_level;

  mode_record_arbiter #(
    .NUM_CH(NUM_CH), .MODE_W(MODE_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .URGENT_MODE(3'd0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
    .out_ch(out_ch), .ch_level(ch_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
  } rec_t;

  typedef struct {
    int                ch;
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   exp_ch;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  rec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LVL_W-1:0] lvl(input int ch);
    return ch_level[ch*LVL_W +: LVL_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input int ch, input logic [MODE_W-1:0] m, input logic [DATA_W-1:0] d);
    in_valid[ch]                = 1'b1;
    in_mode[ch*MODE_W +: MODE_W] = m;
    in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_rec(input int ch, input logic [MODE_W-1:0] m, input logic [DATA_W-1:0] d);
    rec_t r;
    r.ch   = CH_W'(ch);
    r.mode = m;
    r.data = d;
    sb_q.push_back(r);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    sb_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", sb_q.size(), 0);
    chk("drain_idle", out_valid, 0);
  endtask

  // Scoreboard: every accepted output record is matched in order.
  always @(negedge clk) begin
    rec_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch=%0d data=%0h, expected no record", out_ch, out_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_out_ch", out_ch, e.ch);
        chk("sb_out_mode", out_mode, e.mode);
        chk("sb_out_data", out_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   acc;
    vt[0] = '{2, 3'd1, 16'h00A5, 2'd2, 16'h00A5};
    vt[1] = '{0, 3'd0, 16'hFFFF, 2'd0, 16'hFFFF};
    vt[2] = '{3, 3'd7, 16'h0000, 2'd3, 16'h0000};
    vt[3] = '{1, 3'd5, 16'h1234, 2'd1, 16'h1234};
    vt[4] = '{2, 3'd0, 16'h8000, 2'd2, 16'h8000};
    vt[5] = '{0, 3'd3, 16'h5A5A, 2'd0, 16'h5A5A};

    // Reset state and single-record latency table
    do_reset();
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ch_level", ch_level, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    for (int v = 0; v < 6; v++) begin
      out_ready = 1'b1;
      set_rec(vt[v].ch, vt[v].mode, vt[v].data);
      expect_rec(vt[v].exp_ch, vt[v].mode, vt[v].exp_data);
      chk("lat_c0_valid", out_valid, 0);
      tick();
      in_valid = '0;
      chk("lat_c1_valid", out_valid, 0);
      chk("lat_c1_level", lvl(vt[v].ch), 1);
      tick();
      chk("lat_c2_valid", out_valid, 1);
      chk("lat_c2_ch", out_ch, vt[v].exp_ch);
      chk("lat_c2_data", out_data, vt[v].exp_data);
      tick();
      chk("lat_c3_valid", out_valid, 0);
    end
    drain(20);

    // Fairness: 3 non-urgent records per channel, back-to-back 0,1,2,3,...
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        set_rec(c, MODE_W'(1 + c), DATA_W'(16'h2000 + r * 16 + c));
        expect_rec(c, MODE_W'(1 + c), DATA_W'(16'h2000 + r * 16 + c));
      end
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("fair_b2b_valid", out_valid, 1);
      tick();
    end
    chk("fair_end_valid", out_valid, 0);
    drain(20);

    // Urgent head on ch3 beats round-robin, rr pointer left at 3
    do_reset();
    set_rec(3, 3'd0, 16'h3333);
    set_rec(0, 3'd1, 16'h0A0A);
    set_rec(1, 3'd1, 16'h1B1B);
    expect_rec(3, 3'd0, 16'h3333);
    expect_rec(0, 3'd1, 16'h0A0A);
    expect_rec(1, 3'd1, 16'h1B1B);
    tick();
    in_valid = '0;
    tick();
    chk("urg_first_ch", out_ch, 3);
    drain(20);

    // Two urgent heads: lowest index first, then the remaining RR channel
    do_reset();
    set_rec(1, 3'd0, 16'hA111);
    set_rec(2, 3'd0, 16'hA222);
    set_rec(0, 3'd4, 16'hA000);
    expect_rec(1, 3'd0, 16'hA111);
    expect_rec(2, 3'd0, 16'hA222);
    expect_rec(0, 3'd4, 16'hA000);
    tick();
    in_valid = '0;
    drain(20);

    // Full FIFO under backpressure: slot holds one, FIFO holds DEPTH
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_rec(0, 3'd1, DATA_W'(16'hC000 + k));
      expect_rec(0, 3'd1, DATA_W'(16'hC000 + k));
      tick();
    end
    chk("full_level", lvl(0), 4);
    chk("full_in_ready", in_ready[0], 0);
    chk("full_other_ready", in_ready[3:1], 3'b111);
    set_rec(0, 3'd2, 16'hDEAD);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 16'hC000);
    end
    in_valid = '0;
    chk("refused_level", lvl(0), 4);
    drain(30);

    // Pointer wrap: 37 records through ch1 with random backpressure
    do_reset();
    acc = 0;
    for (int cyc = 0; cyc < 3000 && acc < 37; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      set_rec(1, MODE_W'(1 + acc % 7), DATA_W'(16'h1000 + acc));
      if (in_ready[1]) begin
        expect_rec(1, MODE_W'(1 + acc % 7), DATA_W'(16'h1000 + acc));
        acc++;
      end
      tick();
      chk("wrap_level_max", lvl(1) <= 3'd4, 1);
    end
    in_valid = '0;
    chk("wrap_accepted", acc, 37);
    drain(50);

    // Mid-operation reset discards buffered records and the output slot
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_rec(0, 3'd2, DATA_W'(16'hE000 + k));
      tick();
    end
    in_valid = '0;
    chk("midrst_pre_valid", out_valid, 1);
    chk("midrst_pre_level", lvl(0), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", ch_level, 0);
    chk("midrst_in_ready", in_ready, 0);
    sb_q.delete();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("midrst_post_valid", out_valid, 0);
    chk("midrst_post_level", ch_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
